// File: rtl/pipe_trace_buffer.sv
// rtl/pipe_trace_buffer.sv - retire-event trace buffer with PC trigger and saturating event counters
//
// Captures {pc, rd, data} of retired write-back events into a DEPTH-entry
// circular buffer. Capture stops POST entries after a PC-match or forced
// trigger, or immediately on stop. Saturating cycle/retire/stall/flush
// counters run while capturing.
//
// Ports:
//   clk, reset (sync, active-low)
//   wb_valid, wb_pc, wb_rd, wb_data   retire event from MEM/WB
//   stall_i, flush_i                  hazard unit bubble / branch flush
//   arm, stop, force_trig             control pulses
//   trig_en, trig_pc                  PC-match trigger
//   rd_en, rd_addr                    read request, 0 = oldest entry
//   rd_valid, rd_hit, rd_pc, rd_rd, rd_data   registered read response
//   state, count                      00 IDLE, 01 ARMED, 10 POST, 11 FROZEN; valid entries
//   cyc_cnt, ret_cnt, stall_cnt, flush_cnt    event counters

module pipe_trace_buffer #(
   parameter int XLEN  = 32,
   parameter int PC_W  = 32,
   parameter int DEPTH = 16,
   parameter int POST  = 4,
   parameter int CNT_W = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wb_valid,
   input  logic [PC_W-1:0]          wb_pc,
   input  logic [4:0]               wb_rd,
   input  logic [XLEN-1:0]          wb_data,
   input  logic                     stall_i,
   input  logic                     flush_i,
   input  logic                     arm,
   input  logic                     stop,
   input  logic                     trig_en,
   input  logic [PC_W-1:0]          trig_pc,
   input  logic                     force_trig,
   input  logic                     rd_en,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic                     rd_valid,
   output logic                     rd_hit,
   output logic [PC_W-1:0]          rd_pc,
   output logic [4:0]               rd_rd,
   output logic [XLEN-1:0]          rd_data,
   output logic [1:0]               state,
   output logic [$clog2(DEPTH):0]   count,
   output logic [CNT_W-1:0]         cyc_cnt,
   output logic [CNT_W-1:0]         ret_cnt,
   output logic [CNT_W-1:0]         stall_cnt,
   output logic [CNT_W-1:0]         flush_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PONE = AW'(1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_ARMED  = 2'b01,
      S_POST   = 2'b10,
      S_FROZEN = 2'b11
   } state_t;

   state_t st, st_nxt;

   logic [PC_W-1:0] mem_pc   [DEPTH];
   logic [4:0]      mem_rd   [DEPTH];
   logic [XLEN-1:0] mem_data [DEPTH];

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] post_cnt;
   logic          force_pend;

   logic          arm_go, active, wr_en, fire, post_last, cnt_en;
   logic [AW-1:0] rd_phys;
   logic          rd_in;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      return (en && (v != {CNT_W{1'b1}})) ? v + 1'b1 : v;
   endfunction

   // stop beats arm everywhere; in IDLE that means the pair is a no-op.
   assign arm_go    = arm & ~stop;
   assign active    = (st == S_ARMED) || (st == S_POST);
   // The arm cycle restarts capture rather than recording, and a stop
   // freezes before the same-edge entry lands.
   assign wr_en     = active && wb_valid && !stop && !arm_go;
   assign fire      = (st == S_ARMED) && wr_en &&
                      ((trig_en && (wb_pc == trig_pc)) || force_pend || force_trig);
   assign post_last = (st == S_POST) && wr_en && (post_cnt == PONE);
   // The freeze cycle is counted, the arm cycle is not.
   assign cnt_en    = active && !arm_go;

   assign state = st;

   always_ff @(posedge clk) begin
      if (!reset) st <= S_IDLE;
      else        st <= st_nxt;
   end

   always_comb begin
      st_nxt = st;
      case (st)
         S_IDLE: begin
            if (arm_go) st_nxt = S_ARMED;
         end
         S_ARMED: begin
            if (stop)        st_nxt = S_FROZEN;
            else if (arm_go) st_nxt = S_ARMED;
            else if (fire)   st_nxt = (POST == 0) ? S_FROZEN : S_POST;
         end
         S_POST: begin
            if (stop)           st_nxt = S_FROZEN;
            else if (arm_go)    st_nxt = S_ARMED;
            else if (post_last) st_nxt = S_FROZEN;
         end
         S_FROZEN: begin
            if (arm_go) st_nxt = S_ARMED;
         end
         default: st_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr     <= '0;
         count      <= '0;
         post_cnt   <= '0;
         force_pend <= 1'b0;
         cyc_cnt    <= '0;
         ret_cnt    <= '0;
         stall_cnt  <= '0;
         flush_cnt  <= '0;
      end else if (arm_go) begin
         wr_ptr     <= '0;
         count      <= '0;
         post_cnt   <= '0;
         force_pend <= 1'b0;
         cyc_cnt    <= '0;
         ret_cnt    <= '0;
         stall_cnt  <= '0;
         flush_cnt  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (count != FULL) count <= count + 1'b1;
         end
         if (fire)
            post_cnt <= AW'(POST);
         else if ((st == S_POST) && wr_en)
            post_cnt <= post_cnt - 1'b1;
         if (fire)            force_pend <= 1'b0;
         else if (force_trig) force_pend <= 1'b1;
         if (cnt_en) begin
            cyc_cnt   <= sat_inc(cyc_cnt, 1'b1);
            ret_cnt   <= sat_inc(ret_cnt, wb_valid);
            stall_cnt <= sat_inc(stall_cnt, stall_i);
            flush_cnt <= sat_inc(flush_cnt, flush_i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_pc[wr_ptr]   <= wb_pc;
         mem_rd[wr_ptr]   <= wb_rd;
         mem_data[wr_ptr] <= wb_data;
      end
   end

   // When full, count[AW-1:0] is zero, so the oldest entry sits at wr_ptr.
   assign rd_phys = wr_ptr - count[AW-1:0] + rd_addr;
   assign rd_in   = ({1'b0, rd_addr} < count);

   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_valid <= 1'b0;
         rd_hit   <= 1'b0;
         rd_pc    <= '0;
         rd_rd    <= '0;
         rd_data  <= '0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            rd_hit  <= rd_in;
            rd_pc   <= rd_in ? mem_pc[rd_phys]   : '0;
            rd_rd   <= rd_in ? mem_rd[rd_phys]   : '0;
            rd_data <= rd_in ? mem_data[rd_phys] : '0;
         end
      end
   end

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// tb/tb_pipe_trace_buffer.sv - directed self-checking bench for pipe_trace_buffer

module tb_pipe_trace_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_valid;
   logic [31:0] wb_pc;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        stall_i, flush_i, arm, stop, trig_en, force_trig, rd_en;
   logic [31:0] trig_pc;
   logic [3:0]  rd_addr;
   logic        rd_valid, rd_hit;
   logic [31:0] rd_pc;
   logic [4:0]  rd_rd;
   logic [31:0] rd_data;
   logic [1:0]  state;
   logic [4:0]  count;
   logic [3:0]  cyc_cnt, ret_cnt, stall_cnt, flush_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pipe_trace_buffer #(
      .XLEN(32), .PC_W(32), .DEPTH(16), .POST(4), .CNT_W(4)
   ) dut (
      .clk(clk), .reset(reset),
      .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_rd(wb_rd), .wb_data(wb_data),
      .stall_i(stall_i), .flush_i(flush_i),
      .arm(arm), .stop(stop), .trig_en(trig_en), .trig_pc(trig_pc),
      .force_trig(force_trig),
      .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_valid(rd_valid), .rd_hit(rd_hit), .rd_pc(rd_pc), .rd_rd(rd_rd),
      .rd_data(rd_data),
      .state(state), .count(count),
      .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic retire(input logic [31:0] pc, input logic [4:0] r, input logic [31:0] d);
      wb_valid = 1'b1; wb_pc = pc; wb_rd = r; wb_data = d;
      tick;
      wb_valid = 1'b0;
   endtask

   task automatic pulse_arm;
      arm = 1'b1; tick; arm = 1'b0;
   endtask

   task automatic pulse_stop;
      stop = 1'b1; tick; stop = 1'b0;
   endtask

   task automatic read_chk(input logic [3:0] a, input logic hit, input logic [31:0] pc,
                           input logic [4:0] r, input logic [31:0] d);
      rd_en = 1'b1; rd_addr = a;
      tick;
      rd_en = 1'b0;
      chk("rd_valid", rd_valid, 1);
      chk("rd_hit", rd_hit, hit);
      chk("rd_pc", rd_pc, pc);
      chk("rd_rd", rd_rd, r);
      chk("rd_data", rd_data, d);
   endtask

   initial begin
      reset = 1'b0; wb_valid = 0; wb_pc = 0; wb_rd = 0; wb_data = 0;
      stall_i = 0; flush_i = 0; arm = 0; stop = 0; trig_en = 0; trig_pc = 0;
      force_trig = 0; rd_en = 0; rd_addr = 0;

      // reset defaults
      tick; tick;
      reset = 1'b1;
      tick;
      chk("rst_state", state, 2'b00);
      chk("rst_count", count, 0);
      chk("rst_cyc", cyc_cnt, 0);
      chk("rst_ret", ret_cnt, 0);
      chk("rst_stall", stall_cnt, 0);
      chk("rst_flush", flush_cnt, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_hit", rd_hit, 0);

      // stop in IDLE is ignored; arm+stop in IDLE does nothing
      pulse_stop;
      chk("idle_stop_state", state, 2'b00);
      arm = 1'b1; stop = 1'b1; tick; arm = 1'b0; stop = 1'b0;
      chk("idle_armstop_state", state, 2'b00);
      retire(32'h100, 5'd1, 32'd1);
      chk("idle_no_capture", count, 0);

      // basic capture
      pulse_arm;
      chk("basic_armed", state, 2'b01);
      for (int i = 0; i < 5; i++) retire(32'(4 * i), 5'(i + 1), 32'(10 * (i + 1)));
      chk("basic_count_live", count, 5);
      pulse_stop;
      chk("basic_frozen", state, 2'b11);
      chk("basic_count", count, 5);
      chk("basic_cyc", cyc_cnt, 6);
      chk("basic_ret", ret_cnt, 5);
      // back-to-back reads, addr 5 is beyond count
      for (int i = 0; i < 6; i++) begin
         rd_en = 1'b1; rd_addr = 4'(i);
         tick;
         chk("b2b_valid", rd_valid, 1);
         if (i < 5) begin
            chk("b2b_hit", rd_hit, 1);
            chk("b2b_pc", rd_pc, 4 * i);
            chk("b2b_rd", rd_rd, i + 1);
            chk("b2b_data", rd_data, 10 * (i + 1));
         end else begin
            chk("miss_hit", rd_hit, 0);
            chk("miss_pc", rd_pc, 0);
            chk("miss_rd", rd_rd, 0);
            chk("miss_data", rd_data, 0);
         end
      end
      rd_en = 1'b0;
      tick;
      chk("rd_valid_drop", rd_valid, 0);

      // frozen: retires not captured
      retire(32'h200, 5'd9, 32'd9);
      chk("frozen_count", count, 5);
      chk("frozen_ret", ret_cnt, 5);

      // wrap-around, counter saturation at 15
      pulse_arm;
      chk("wrap_cleared", count, 0);
      for (int i = 0; i < 20; i++) retire(32'(4 * i), 5'(i), 32'(i));
      pulse_stop;
      chk("wrap_count", count, 16);
      chk("wrap_ret_sat", ret_cnt, 15);
      chk("wrap_cyc_sat", cyc_cnt, 15);
      read_chk(4'd0, 1'b1, 32'h10, 5'd4, 32'd4);
      read_chk(4'd15, 1'b1, 32'h4C, 5'd19, 32'd19);

      // PC trigger, POST=4
      trig_en = 1'b1; trig_pc = 32'h20;
      pulse_arm;
      for (int i = 0; i <= 16; i++) begin
         retire(32'(4 * i), 5'(i), 32'(100 + i));
         if (i == 8)  chk("trig_post", state, 2'b10);
         if (i == 11) chk("trig_still_post", state, 2'b10);
         if (i == 12) chk("trig_frozen", state, 2'b11);
      end
      trig_en = 1'b0;
      chk("trig_ret", ret_cnt, 13);
      chk("trig_count", count, 13);
      chk("trig_cyc", cyc_cnt, 13);
      read_chk(4'd12, 1'b1, 32'h30, 5'd12, 32'd112);
      read_chk(4'd13, 1'b0, 32'h0, 5'd0, 32'd0);

      // forced trigger on the next captured entry
      pulse_arm;
      force_trig = 1'b1; tick; force_trig = 1'b0;
      retire(32'h500, 5'd1, 32'd1);
      chk("force_post", state, 2'b10);
      for (int i = 0; i < 4; i++) retire(32'h504 + 32'(4 * i), 5'd2, 32'd2);
      chk("force_frozen", state, 2'b11);
      chk("force_count", count, 5);

      // counters and saturation
      pulse_arm;
      for (int i = 0; i < 20; i++) begin
         stall_i = 1'b1;
         flush_i = (i == 2 || i == 5 || i == 9);
         tick;
      end
      stall_i = 1'b0; flush_i = 1'b0;
      pulse_stop;
      chk("cnt_cyc", cyc_cnt, 15);
      chk("cnt_stall", stall_cnt, 15);
      chk("cnt_flush", flush_cnt, 3);
      chk("cnt_ret", ret_cnt, 0);
      tick;
      chk("cnt_hold_frozen", cyc_cnt, 15);

      // arm+stop while ARMED: freeze, contents kept
      pulse_arm;
      for (int i = 0; i < 3; i++) retire(32'h800 + 32'(4 * i), 5'(i + 7), 32'(70 + i));
      arm = 1'b1; stop = 1'b1; tick; arm = 1'b0; stop = 1'b0;
      chk("col_frozen", state, 2'b11);
      chk("col_count", count, 3);
      read_chk(4'd2, 1'b1, 32'h808, 5'd9, 32'd72);

      // reset in POST
      pulse_arm;
      force_trig = 1'b1; tick; force_trig = 1'b0;
      retire(32'h900, 5'd3, 32'd3);
      chk("rst_post_pre", state, 2'b10);
      reset = 1'b0; tick; reset = 1'b1;
      chk("rst_post_state", state, 2'b00);
      chk("rst_post_count", count, 0);
      chk("rst_post_cyc", cyc_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
